// File: rtl/regbank_sq_if.sv
// Bus between the control unit and the banked GF(2^m) operand store / squaring engine.
// master = control unit side, slave = regbank_sq_engine side.
interface regbank_sq_if #(
  parameter int WIDTH  = 233,
  parameter int AW     = 4,
  parameter int NBANKS = 3,
  parameter int SQW    = 4
);
  logic [NBANKS*AW-1:0]    raddr1;
  logic [NBANKS*AW-1:0]    raddr2;
  logic [NBANKS-1:0]       we;
  logic [NBANKS*AW-1:0]    waddr;
  logic [NBANKS*WIDTH-1:0] wdata;
  logic [NBANKS*WIDTH-1:0] rdata1;
  logic [NBANKS*WIDTH-1:0] rdata2;
  logic                    sq_start;
  logic [1:0]              sq_bank;
  logic [AW-1:0]           sq_src;
  logic [AW-1:0]           sq_dst;
  logic [SQW-1:0]          sq_count;
  logic                    sq_busy;
  logic                    sq_done;
  logic                    sq_wr_conflict;

  modport master (
    output raddr1, raddr2, we, waddr, wdata,
    output sq_start, sq_bank, sq_src, sq_dst, sq_count,
    input  rdata1, rdata2, sq_busy, sq_done, sq_wr_conflict
  );

  modport slave (
    input  raddr1, raddr2, we, waddr, wdata,
    input  sq_start, sq_bank, sq_src, sq_dst, sq_count,
    output rdata1, rdata2, sq_busy, sq_done, sq_wr_conflict
  );
endinterface

// File: rtl/regbank_sq_engine.sv
// Banked GF(2^m) operand store (NBANKS x dual-read/single-write, registered reads)
// with an iterative k-fold squaring engine that writes back into the source bank.
// Optional feature: REG_BANK_BYPASS_EN forwards same-edge write data to the read registers.
//
// state  | meaning
// S_IDLE | waiting for sq_start
// S_SQ   | one squaring mod x^WIDTH + x^POLY_TAP + 1 per cycle
// S_WB   | write acc back to array[bank][dst]
module regbank_sq_engine #(
  parameter int WIDTH    = 233,
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int NBANKS   = 3,
  parameter int POLY_TAP = 74,
  parameter int SQW      = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  regbank_sq_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_SQ, S_WB} state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        acc_q, acc_d;
  logic [SQW-1:0]          cnt_q, cnt_d;
  logic [1:0]              bank_q, bank_d;
  logic [AW-1:0]           dst_q, dst_d;

  logic [WIDTH-1:0]        mem_q [NBANKS][DEPTH];
  logic [NBANKS-1:0]       wr_en, wb_hit;
  logic [AW-1:0]           wr_addr [NBANKS];
  logic [WIDTH-1:0]        wr_data [NBANKS];
  logic [NBANKS*WIDTH-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  logic [WIDTH-1:0]        src_word;

  function automatic logic in_range(input logic [AW-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  // Spread to 2*WIDTH-1 bits, then fold the high half down through the trinomial.
  function automatic logic [WIDTH-1:0] gf_sq(input logic [WIDTH-1:0] a);
    logic [2*WIDTH-2:0] t;
    t = '0;
    for (int i = 0; i < WIDTH; i++) t[2*i] = a[i];
    for (int j = 2*WIDTH-2; j >= WIDTH; j--) begin
      if (t[j]) begin
        t[j-WIDTH]          = ~t[j-WIDTH];
        t[j-WIDTH+POLY_TAP] = ~t[j-WIDTH+POLY_TAP];
        t[j]                = 1'b0;
      end
    end
    return t[WIDTH-1:0];
  endfunction

  // Effective write per bank: engine write-back wins over the external port.
  always_comb begin
    wb_hit = '0;
    wr_en  = '0;
    for (int b = 0; b < NBANKS; b++) begin
      wb_hit[b]  = (state_q == S_WB) && (int'(bank_q) == b);
      wr_addr[b] = bus.waddr[b*AW +: AW];
      wr_data[b] = bus.wdata[b*WIDTH +: WIDTH];
      if (wb_hit[b]) begin
        wr_addr[b] = dst_q;
        wr_data[b] = acc_q;
        wr_en[b]   = in_range(dst_q);
      end else begin
        wr_en[b]   = bus.we[b] && in_range(bus.waddr[b*AW +: AW]);
      end
    end
  end

  // Next read data; out-of-range addresses read as zero.
  always_comb begin
    logic [AW-1:0] a1, a2;
    a1       = '0;
    a2       = '0;
    rdata1_d = '0;
    rdata2_d = '0;
    for (int b = 0; b < NBANKS; b++) begin
      a1 = bus.raddr1[b*AW +: AW];
      a2 = bus.raddr2[b*AW +: AW];
      if (in_range(a1)) rdata1_d[b*WIDTH +: WIDTH] = mem_q[b][a1];
      if (in_range(a2)) rdata2_d[b*WIDTH +: WIDTH] = mem_q[b][a2];
`ifdef REG_BANK_BYPASS_EN
      if (wr_en[b] && (wr_addr[b] == a1)) rdata1_d[b*WIDTH +: WIDTH] = wr_data[b];
      if (wr_en[b] && (wr_addr[b] == a2)) rdata2_d[b*WIDTH +: WIDTH] = wr_data[b];
`endif
    end
  end

  // Source operand seen by the engine at start: array contents before this edge's write.
  always_comb begin
    src_word = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if ((int'(bus.sq_bank) == b) && in_range(bus.sq_src)) src_word = mem_q[b][bus.sq_src];
    end
  end

  // Engine next-state and datapath.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    dst_d   = dst_q;
    case (state_q)
      S_IDLE: begin
        if (bus.sq_start) begin
          acc_d   = src_word;
          bank_d  = bus.sq_bank;
          dst_d   = bus.sq_dst;
          cnt_d   = bus.sq_count;
          state_d = (bus.sq_count == '0) ? S_WB : S_SQ;
        end
      end
      S_SQ: begin
        acc_d = gf_sq(acc_q);
        cnt_d = cnt_q - SQW'(1);
        if (cnt_q == SQW'(1)) state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Engine registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      bank_q  <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      dst_q   <= dst_d;
    end
  end

  // Read data registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
    end
  end

  // Storage array: not reset, and held untouched while reset is asserted.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NBANKS; b++) begin
      if (rst_n_i && wr_en[b]) mem_q[b][wr_addr[b]] <= wr_data[b];
    end
  end

  assign bus.rdata1         = rdata1_q;
  assign bus.rdata2         = rdata2_q;
  assign bus.sq_busy        = (state_q != S_IDLE);
  assign bus.sq_done        = (state_q == S_WB);
  assign bus.sq_wr_conflict = |(wb_hit & bus.we);

endmodule

// File: tb/tb_regbank_sq_engine.sv
// Directed bench for regbank_sq_engine with hand-computed expected values.
module tb_regbank_sq_engine;
  localparam int W  = 233;
  localparam int AW = 4;
  localparam int NB = 3;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_mis = 0;

  regbank_sq_if #(.WIDTH(W), .AW(AW), .NBANKS(NB), .SQW(4)) bus ();

  regbank_sq_engine dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] bitw(input int i);
    logic [W-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_wr(input int b, input logic en, input logic [AW-1:0] a, input logic [W-1:0] d);
    bus.we[b] = en;
    bus.waddr[b*AW +: AW] = a;
    bus.wdata[b*W +: W] = d;
  endtask

  task automatic write1(input int b, input logic [AW-1:0] a, input logic [W-1:0] d);
    set_wr(b, 1'b1, a, d);
    tick();
    bus.we = '0;
  endtask

  task automatic set_rd(input int b, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    bus.raddr1[b*AW +: AW] = a1;
    bus.raddr2[b*AW +: AW] = a2;
  endtask

  function automatic logic [W-1:0] rd1(input int b);
    return bus.rdata1[b*W +: W];
  endfunction

  function automatic logic [W-1:0] rd2(input int b);
    return bus.rdata2[b*W +: W];
  endfunction

  // Start the engine, measure busy length and done position, then read dst back.
  task automatic sq_run(input string tag, input int b, input logic [AW-1:0] src,
                        input logic [AW-1:0] dst, input int k, input logic [W-1:0] exp);
    int n, done_at;
    n = 0;
    done_at = 99;
    bus.sq_start = 1'b1;
    bus.sq_bank  = 2'(b);
    bus.sq_src   = src;
    bus.sq_dst   = dst;
    bus.sq_count = 4'(k);
    tick();
    bus.sq_start = 1'b0;
    while (bus.sq_busy === 1'b1 && n < 40) begin
      if (bus.sq_done === 1'b1 && done_at == 99) done_at = n;
      n++;
      tick();
    end
    check({tag, "_busy_len"}, W'(n), W'(k + 1));
    check({tag, "_done_at"}, W'(done_at), W'(k));
    set_rd(b, dst, 4'd0);
    tick();
    check({tag, "_result"}, rd1(b), exp);
  endtask

  initial begin
    logic saw_done;
    rst_n        = 1'b0;
    bus.raddr1   = '0;
    bus.raddr2   = '0;
    bus.we       = '0;
    bus.waddr    = '0;
    bus.wdata    = '0;
    bus.sq_start = 1'b0;
    bus.sq_bank  = '0;
    bus.sq_src   = '0;
    bus.sq_dst   = '0;
    bus.sq_count = '0;
    repeat (3) tick();

    check("rst_rdata1_b0", rd1(0), '0);
    check("rst_rdata2_b2", rd2(2), '0);
    check("rst_busy", W'(bus.sq_busy), '0);
    check("rst_done", W'(bus.sq_done), '0);
    check("rst_conflict", W'(bus.sq_wr_conflict), '0);

    rst_n = 1'b1;
    // Known zero in word 0 of every bank so unaddressed ports read defined data.
    for (int b = 0; b < NB; b++) set_wr(b, 1'b1, 4'd0, '0);
    tick();
    bus.we = '0;

    // Plain write, read next cycle.
    write1(0, 4'd3, W'(20'h12345));
    set_rd(0, 4'd3, 4'd0);
    tick();
    check("wr_rd_b0", rd1(0), W'(20'h12345));
    check("rd2_b0_other", rd2(0), '0);
    check("rd1_b1_other", rd1(1), '0);
    set_rd(0, 4'd0, 4'd0);

    // x^116 squared = x^232 (no reduction).
    write1(1, 4'd2, bitw(116));
    sq_run("sq116", 1, 4'd2, 4'd5, 1, bitw(232));
    // x^117 squared = x^234 -> x^1 + x^75.
    write1(2, 4'd0, bitw(117));
    sq_run("sq117", 2, 4'd0, 4'd1, 1, bitw(1) | bitw(75));
    // x^200 squared = x^400 -> x^167 + x^241 -> x^167 + x^8 + x^82.
    write1(0, 4'd8, bitw(200));
    sq_run("sq200", 0, 4'd8, 4'd9, 1, bitw(8) | bitw(82) | bitw(167));
    // 1 squared 15 times stays 1; busy for 16 cycles.
    write1(2, 4'd0, W'(1));
    sq_run("sq1x15", 2, 4'd0, 4'd2, 15, W'(1));

    // Copy (k=0) with a colliding external write in the WB cycle.
    write1(0, 4'd4, W'(16'hABCD));
    bus.sq_start = 1'b1;
    bus.sq_bank  = 2'd0;
    bus.sq_src   = 4'd4;
    bus.sq_dst   = 4'd7;
    bus.sq_count = 4'd0;
    tick();
    bus.sq_start = 1'b0;
    set_wr(0, 1'b1, 4'd7, W'(16'h1111));
    set_wr(1, 1'b1, 4'd7, W'(16'h2222));
    #1;
    check("copy_done", W'(bus.sq_done), W'(1));
    check("copy_conflict", W'(bus.sq_wr_conflict), W'(1));
    tick();
    bus.we = '0;
    #1;
    check("copy_busy_after", W'(bus.sq_busy), '0);
    check("copy_conflict_after", W'(bus.sq_wr_conflict), '0);
    set_rd(0, 4'd7, 4'd0);
    set_rd(1, 4'd7, 4'd0);
    tick();
    check("copy_result", rd1(0), W'(16'hABCD));
    check("other_bank_write", rd1(1), W'(16'h2222));

    // Read during write of the same address.
    write1(1, 4'd9, W'(8'hAA));
    set_wr(1, 1'b1, 4'd9, W'(8'h55));
    set_rd(1, 4'd9, 4'd9);
    tick();
    bus.we = '0;
`ifdef REG_BANK_BYPASS_EN
    check("rdw_rd1", rd1(1), W'(8'h55));
    check("rdw_rd2", rd2(1), W'(8'h55));
`else
    check("rdw_rd1", rd1(1), W'(8'hAA));
    check("rdw_rd2", rd2(1), W'(8'hAA));
`endif
    tick();
    check("rdw_next", rd1(1), W'(8'h55));

    // Reset while squaring: no write-back, engine restartable.
    write1(0, 4'd10, W'(8'h77));
    write1(0, 4'd11, W'(8'h03));
    bus.sq_start = 1'b1;
    bus.sq_bank  = 2'd0;
    bus.sq_src   = 4'd11;
    bus.sq_dst   = 4'd10;
    bus.sq_count = 4'd8;
    tick();
    bus.sq_start = 1'b0;
    tick();
    check("pre_rst_busy", W'(bus.sq_busy), W'(1));
    rst_n = 1'b0;
    tick();
    check("mid_rst_busy", W'(bus.sq_busy), '0);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.sq_done === 1'b1) saw_done = 1'b1;
      tick();
    end
    check("no_done_after_rst", W'(saw_done), '0);
    set_rd(0, 4'd10, 4'd0);
    tick();
    check("dst_unchanged", rd1(0), W'(8'h77));
    // (x+1)^2 = x^2 + 1
    sq_run("restart", 0, 4'd11, 4'd12, 1, W'(3'b101));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
